// File: rtl/nv_nvdla_sdp_x_int_pipe_pkg.sv
// Shared definitions for the SDP X-stage INT datapath: lane widths, ALU
// algorithm encodings and INT32 saturation helpers.
package nv_nvdla_sdp_x_int_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 16;
  localparam int ALU_W  = 33;
  localparam int MUL_W  = 49;
  localparam int TRT_W  = 65;

  localparam int ALU_SHIFT_MAX = 16;

  typedef enum logic [1:0] {
    ALU_MAX = 2'd0,
    ALU_MIN = 2'd1,
    ALU_SUM = 2'd2,
    ALU_EQL = 2'd3
  } alu_algo_e;

  localparam logic signed [DATA_W-1:0] INT32_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [DATA_W-1:0] INT32_MIN = 32'sh8000_0000;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sat;
  } sat_res_t;

  // Clamp a wide signed value into INT32 and flag whether clamping happened.
  function automatic sat_res_t sat_int32(input logic signed [TRT_W-1:0] v);
    sat_res_t r;
    if (v > INT32_MAX) begin
      r.data = INT32_MAX;
      r.sat  = 1'b1;
    end else if (v < INT32_MIN) begin
      r.data = INT32_MIN;
      r.sat  = 1'b1;
    end else begin
      r.data = v[DATA_W-1:0];
      r.sat  = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/nv_nvdla_sdp_x_int_pipe_if.sv
// Lane-vectorised stream bundle of the X-stage pipe: data in, ALU/MUL operand
// streams and result out. The slave modport is the pipe's view.
interface nv_nvdla_sdp_x_int_pipe_if
  import nv_nvdla_sdp_x_int_pipe_pkg::*;
#(
  parameter int LANES = 4
);

  logic [LANES*DATA_W-1:0] chn_data_in;
  logic                    chn_in_pvld;
  logic                    chn_in_prdy;

  logic [LANES*OP_W-1:0]   chn_alu_op;
  logic                    chn_alu_op_pvld;
  logic                    chn_alu_op_prdy;

  logic [LANES*OP_W-1:0]   chn_mul_op;
  logic                    chn_mul_op_pvld;
  logic                    chn_mul_op_prdy;

  logic [LANES*DATA_W-1:0] chn_data_out;
  logic                    chn_out_pvld;
  logic                    chn_out_prdy;

  modport master (
    output chn_data_in, chn_in_pvld,
    output chn_alu_op, chn_alu_op_pvld,
    output chn_mul_op, chn_mul_op_pvld,
    output chn_out_prdy,
    input  chn_in_prdy, chn_alu_op_prdy, chn_mul_op_prdy,
    input  chn_data_out, chn_out_pvld
  );

  modport slave (
    input  chn_data_in, chn_in_pvld,
    input  chn_alu_op, chn_alu_op_pvld,
    input  chn_mul_op, chn_mul_op_pvld,
    input  chn_out_prdy,
    output chn_in_prdy, chn_alu_op_prdy, chn_mul_op_prdy,
    output chn_data_out, chn_out_pvld
  );

endinterface

// File: rtl/nv_nvdla_sdp_x_int_lane.sv
// One 32-bit lane of the X-stage: ALU -> S1 -> MUL -> S2 -> TRT/saturate/ReLU -> S3.
// Stage enables come from the shared valid chain in the top.
module nv_nvdla_sdp_x_int_lane
  import nv_nvdla_sdp_x_int_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s1_en,
  input  logic              s2_en,
  input  logic              s3_en,
  input  logic              cfg_alu_bypass,
  input  logic              cfg_alu_src,
  input  logic [1:0]        cfg_alu_algo,
  input  logic [15:0]       cfg_alu_op,
  input  logic [5:0]        cfg_alu_shift_value,
  input  logic              cfg_mul_bypass,
  input  logic              cfg_mul_src,
  input  logic              cfg_mul_prelu,
  input  logic [15:0]       cfg_mul_op,
  input  logic [5:0]        cfg_mul_shift_value,
  input  logic              cfg_relu_bypass,
  input  logic [DATA_W-1:0] data,
  input  logic [OP_W-1:0]   alu_chn_op,
  input  logic [OP_W-1:0]   mul_chn_op,
  output logic [DATA_W-1:0] result,
  output logic              sat
);

  logic [OP_W-1:0]         alu_op_sel;
  logic [OP_W-1:0]         mul_op_sel;
  logic [4:0]              alu_shamt;
  logic signed [ALU_W-1:0] alu_a;
  logic signed [ALU_W-1:0] alu_op_ext;
  logic signed [ALU_W-1:0] alu_operand;
  logic signed [ALU_W-1:0] alu_res;

  logic signed [ALU_W-1:0] s1_alu;
  logic [OP_W-1:0]         s1_mul_op;

  logic signed [MUL_W-1:0] mul_a;
  logic signed [MUL_W-1:0] mul_b;
  logic signed [MUL_W-1:0] mul_prod;
  logic                    mul_skip;
  logic signed [MUL_W-1:0] mul_res;

  logic signed [MUL_W-1:0] s2_mul;
  logic                    s2_skip;

  logic signed [TRT_W-1:0] trt_x;
  logic signed [TRT_W-1:0] trt_rnd;
  logic signed [TRT_W-1:0] trt_val;
  sat_res_t                trt_sat;
  logic [DATA_W-1:0]       relu_out;

  assign alu_op_sel  = cfg_alu_src ? alu_chn_op : cfg_alu_op;
  assign mul_op_sel  = cfg_mul_src ? mul_chn_op : cfg_mul_op;
  assign alu_shamt   = (cfg_alu_shift_value > 6'(ALU_SHIFT_MAX)) ? 5'(ALU_SHIFT_MAX)
                                                                 : cfg_alu_shift_value[4:0];
  assign alu_a       = {data[DATA_W-1], data};
  assign alu_op_ext  = {{(ALU_W-OP_W){alu_op_sel[OP_W-1]}}, alu_op_sel};
  assign alu_operand = alu_op_ext <<< alu_shamt;

  // 33-bit ALU: wide enough that SUM of two 32-bit-range values cannot overflow.
  always_comb begin
    alu_res = alu_a;
    if (!cfg_alu_bypass) begin
      case (alu_algo_e'(cfg_alu_algo))
        ALU_MAX: alu_res = (alu_a > alu_operand) ? alu_a : alu_operand;
        ALU_MIN: alu_res = (alu_a < alu_operand) ? alu_a : alu_operand;
        ALU_SUM: alu_res = alu_a + alu_operand;
        ALU_EQL: alu_res = (alu_a == alu_operand) ? 33'sd1 : 33'sd0;
        default: alu_res = alu_a;
      endcase
    end
  end

  // The MUL operand is captured alongside the ALU result since its stream is
  // consumed in the accept cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_alu    <= '0;
      s1_mul_op <= '0;
    end else if (s1_en) begin
      s1_alu    <= alu_res;
      s1_mul_op <= mul_op_sel;
    end
  end

  assign mul_a    = {{(MUL_W-ALU_W){s1_alu[ALU_W-1]}}, s1_alu};
  assign mul_b    = {{(MUL_W-OP_W){s1_mul_op[OP_W-1]}}, s1_mul_op};
  assign mul_prod = mul_a * mul_b;
  assign mul_skip = cfg_mul_bypass || (cfg_mul_prelu && !s1_alu[ALU_W-1]);
  assign mul_res  = mul_skip ? mul_a : mul_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_mul  <= '0;
      s2_skip <= 1'b0;
    end else if (s2_en) begin
      s2_mul  <= mul_res;
      s2_skip <= mul_skip;
    end
  end

  // Round-half-up right shift; 65 bits leave headroom for a 2^62 rounding term.
  always_comb begin
    trt_x   = {{(TRT_W-MUL_W){s2_mul[MUL_W-1]}}, s2_mul};
    trt_rnd = '0;
    trt_val = trt_x;
    if (!s2_skip && (cfg_mul_shift_value != 6'd0)) begin
      trt_rnd[{1'b0, cfg_mul_shift_value} - 7'd1] = 1'b1;
      trt_val = (trt_x + trt_rnd) >>> cfg_mul_shift_value;
    end
    trt_sat  = sat_int32(trt_val);
    relu_out = trt_sat.data;
    if (!cfg_relu_bypass && trt_sat.data[DATA_W-1]) begin
      relu_out = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      sat    <= 1'b0;
    end else if (s3_en) begin
      result <= relu_out;
      sat    <= trt_sat.sat;
    end
  end

endmodule

// File: rtl/nv_nvdla_sdp_x_int_pipe.sv
// SDP X-stage INT pipe: joins data/ALU/MUL streams, runs LANES lane slices
// through a three-stage skid-free pipeline and counts saturated lanes.
module nv_nvdla_sdp_x_int_pipe
  import nv_nvdla_sdp_x_int_pipe_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 32
)(
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             cfg_alu_bypass,
  input  logic             cfg_alu_src,
  input  logic [1:0]       cfg_alu_algo,
  input  logic [15:0]      cfg_alu_op,
  input  logic [5:0]       cfg_alu_shift_value,
  input  logic             cfg_mul_bypass,
  input  logic             cfg_mul_src,
  input  logic             cfg_mul_prelu,
  input  logic [15:0]      cfg_mul_op,
  input  logic [5:0]       cfg_mul_shift_value,
  input  logic             cfg_relu_bypass,
  nv_nvdla_sdp_x_int_pipe_if.slave chn,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] sat_cnt,
  output logic             pipe_idle
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + 1;

  logic             alu_used;
  logic             mul_used;
  logic             alu_ok;
  logic             mul_ok;
  logic             accept;
  logic             s1_vld, s2_vld, s3_vld;
  logic             s1_rdy, s2_rdy, s3_rdy;
  logic             s1_en, s2_en, s3_en;
  logic             out_fire;
  logic [LANES-1:0] lane_sat;
  logic [POP_W-1:0] sat_pop;
  logic [SUM_W-1:0] sat_sum;

  assign alu_used = !cfg_alu_bypass && cfg_alu_src;
  assign mul_used = !cfg_mul_bypass && cfg_mul_src;
  assign alu_ok   = !alu_used || chn.chn_alu_op_pvld;
  assign mul_ok   = !mul_used || chn.chn_mul_op_pvld;

  // Each stream's ready waits on its partners so all used streams pop together.
  assign chn.chn_in_prdy     = s1_rdy && alu_ok && mul_ok;
  assign chn.chn_alu_op_prdy = alu_used && s1_rdy && chn.chn_in_pvld && mul_ok;
  assign chn.chn_mul_op_prdy = mul_used && s1_rdy && chn.chn_in_pvld && alu_ok;
  assign accept              = chn.chn_in_pvld && chn.chn_in_prdy;

  assign s3_rdy = !s3_vld || chn.chn_out_prdy;
  assign s2_rdy = !s2_vld || s3_rdy;
  assign s1_rdy = !s1_vld || s2_rdy;

  assign s1_en    = accept;
  assign s2_en    = s1_vld && s2_rdy;
  assign s3_en    = s2_vld && s3_rdy;
  assign out_fire = s3_vld && chn.chn_out_prdy;

  assign chn.chn_out_pvld = s3_vld;
  assign pipe_idle        = !(s1_vld || s2_vld || s3_vld);

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else begin
      if (s1_rdy) s1_vld <= accept;
      if (s2_rdy) s2_vld <= s1_vld;
      if (s3_rdy) s3_vld <= s2_vld;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    nv_nvdla_sdp_x_int_lane u_lane (
      .clk                 (nvdla_core_clk),
      .rst_n               (nvdla_core_rstn),
      .s1_en               (s1_en),
      .s2_en               (s2_en),
      .s3_en               (s3_en),
      .cfg_alu_bypass      (cfg_alu_bypass),
      .cfg_alu_src         (cfg_alu_src),
      .cfg_alu_algo        (cfg_alu_algo),
      .cfg_alu_op          (cfg_alu_op),
      .cfg_alu_shift_value (cfg_alu_shift_value),
      .cfg_mul_bypass      (cfg_mul_bypass),
      .cfg_mul_src         (cfg_mul_src),
      .cfg_mul_prelu       (cfg_mul_prelu),
      .cfg_mul_op          (cfg_mul_op),
      .cfg_mul_shift_value (cfg_mul_shift_value),
      .cfg_relu_bypass     (cfg_relu_bypass),
      .data                (chn.chn_data_in[DATA_W*g +: DATA_W]),
      .alu_chn_op          (chn.chn_alu_op[OP_W*g +: OP_W]),
      .mul_chn_op          (chn.chn_mul_op[OP_W*g +: OP_W]),
      .result              (chn.chn_data_out[DATA_W*g +: DATA_W]),
      .sat                 (lane_sat[g])
    );
  end

  always_comb begin
    sat_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      sat_pop = sat_pop + POP_W'(lane_sat[i]);
    end
  end

  assign sat_sum = {1'b0, sat_cnt} + SUM_W'(sat_pop);

  // Counter sticks at all-ones; a clear beats a same-cycle increment.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (out_fire) begin
      sat_cnt <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_nv_nvdla_sdp_x_int_pipe.sv
// Scoreboard bench for the X-stage INT pipe: a behavioural lane model fills an
// expected queue on every accepted beat and each output beat is checked against it.
module tb_nv_nvdla_sdp_x_int_pipe;

  localparam int LANES = 4;
  localparam int CNT_W = 32;
  localparam int DW    = LANES * 32;

  logic             nvdla_core_clk = 1'b0;
  logic             nvdla_core_rstn;
  logic             cfg_alu_bypass, cfg_alu_src;
  logic [1:0]       cfg_alu_algo;
  logic [15:0]      cfg_alu_op;
  logic [5:0]       cfg_alu_shift_value;
  logic             cfg_mul_bypass, cfg_mul_src, cfg_mul_prelu;
  logic [15:0]      cfg_mul_op;
  logic [5:0]       cfg_mul_shift_value;
  logic             cfg_relu_bypass;
  logic             sat_clr;
  logic [CNT_W-1:0] sat_cnt;
  logic             pipe_idle;

  nv_nvdla_sdp_x_int_pipe_if #(.LANES(LANES)) chn_if ();

  nv_nvdla_sdp_x_int_pipe #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk      (nvdla_core_clk),
    .nvdla_core_rstn     (nvdla_core_rstn),
    .cfg_alu_bypass      (cfg_alu_bypass),
    .cfg_alu_src         (cfg_alu_src),
    .cfg_alu_algo        (cfg_alu_algo),
    .cfg_alu_op          (cfg_alu_op),
    .cfg_alu_shift_value (cfg_alu_shift_value),
    .cfg_mul_bypass      (cfg_mul_bypass),
    .cfg_mul_src         (cfg_mul_src),
    .cfg_mul_prelu       (cfg_mul_prelu),
    .cfg_mul_op          (cfg_mul_op),
    .cfg_mul_shift_value (cfg_mul_shift_value),
    .cfg_relu_bypass     (cfg_relu_bypass),
    .chn                 (chn_if),
    .sat_clr             (sat_clr),
    .sat_cnt             (sat_cnt),
    .pipe_idle           (pipe_idle)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  typedef struct {
    logic [DW-1:0] data;
    int            sats;
    int            cyc;
  } exp_t;

  exp_t          sb[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            cyc      = 0;
  longint        sat_model = 0;
  bit            lat_chk  = 1'b0;
  bit            last_fire;
  logic [DW-1:0] last_out;

  always @(posedge nvdla_core_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] model_lane(input logic [31:0] d, input logic [15:0] aop,
                                             input logic [15:0] mop, output bit sat);
    logic [15:0] asel, msel;
    longint      a, opnd, alu, x;
    int          sh, s;
    bit          skip;
    logic [31:0] r;
    asel = cfg_alu_src ? aop : cfg_alu_op;
    msel = cfg_mul_src ? mop : cfg_mul_op;
    a    = longint'($signed(d));
    sh   = (cfg_alu_shift_value > 6'd16) ? 16 : int'(cfg_alu_shift_value);
    opnd = longint'($signed(asel)) * (longint'(1) << sh);
    case (cfg_alu_algo)
      2'd0:    alu = (a > opnd) ? a : opnd;
      2'd1:    alu = (a < opnd) ? a : opnd;
      2'd2:    alu = a + opnd;
      default: alu = (a == opnd) ? 1 : 0;
    endcase
    if (cfg_alu_bypass) alu = a;
    skip = cfg_mul_bypass || (cfg_mul_prelu && alu >= 0);
    x    = skip ? alu : alu * longint'($signed(msel));
    s    = int'(cfg_mul_shift_value);
    if (!skip && s != 0) x = (x + (longint'(1) << (s - 1))) >>> s;
    sat = 1'b1;
    if (x > 64'sd2147483647) r = 32'h7FFF_FFFF;
    else if (x < -64'sd2147483648) r = 32'h8000_0000;
    else begin
      sat = 1'b0;
      r   = x[31:0];
    end
    if (!cfg_relu_bypass && r[31]) r = '0;
    return r;
  endfunction

  function automatic exp_t model_beat();
    exp_t        e;
    bit          s;
    logic [31:0] r;
    e.data = '0;
    e.sats = 0;
    e.cyc  = cyc;
    for (int i = 0; i < LANES; i++) begin
      r = model_lane(chn_if.chn_data_in[32*i +: 32], chn_if.chn_alu_op[16*i +: 16],
                     chn_if.chn_mul_op[16*i +: 16], s);
      e.data[32*i +: 32] = r;
      e.sats += int'(s);
    end
    return e;
  endfunction

  // One clock: entered at a falling edge with inputs driven, samples just before the rising edge.
  task automatic tick();
    exp_t e;
    bit   alu_used, mul_used, out_fire;
    #4;
    alu_used  = !cfg_alu_bypass && cfg_alu_src;
    mul_used  = !cfg_mul_bypass && cfg_mul_src;
    last_fire = chn_if.chn_in_pvld && chn_if.chn_in_prdy &&
                (!alu_used || chn_if.chn_alu_op_pvld) && (!mul_used || chn_if.chn_mul_op_pvld);
    if (last_fire) sb.push_back(model_beat());
    out_fire = chn_if.chn_out_pvld && chn_if.chn_out_prdy;
    if (out_fire) begin
      if (sb.size() == 0) checkOutput("spurious_beat", 1, 0);
      else begin
        e        = sb.pop_front();
        last_out = chn_if.chn_data_out;
        checkOutput("beat", chn_if.chn_data_out, e.data);
        if (lat_chk) checkOutput("latency", DW'(cyc - e.cyc), 3);
        if (!sat_clr) sat_model += e.sats;
      end
    end
    if (sat_clr) sat_model = 0;
    @(negedge nvdla_core_clk);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic [LANES*16-1:0] aop,
                               input logic [LANES*16-1:0] mop);
    int n = 0;
    chn_if.chn_data_in     = d;
    chn_if.chn_alu_op      = aop;
    chn_if.chn_mul_op      = mop;
    chn_if.chn_in_pvld     = 1'b1;
    chn_if.chn_alu_op_pvld = 1'b1;
    chn_if.chn_mul_op_pvld = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_fire && n < 50);
    if (!last_fire) checkOutput("accept_timeout", 0, 1);
    chn_if.chn_in_pvld     = 1'b0;
    chn_if.chn_alu_op_pvld = 1'b0;
    chn_if.chn_mul_op_pvld = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    chn_if.chn_out_prdy = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", DW'(sb.size()), 0);
  endtask

  task automatic cfg_bypass_all();
    cfg_alu_bypass = 1'b1; cfg_alu_src = 1'b0; cfg_alu_algo = 2'd0;
    cfg_alu_op = '0; cfg_alu_shift_value = '0;
    cfg_mul_bypass = 1'b1; cfg_mul_src = 1'b0; cfg_mul_prelu = 1'b0;
    cfg_mul_op = '0; cfg_mul_shift_value = '0;
    cfg_relu_bypass = 1'b1;
  endtask

  initial begin
    int budget, sent;
    nvdla_core_rstn        = 1'b0;
    sat_clr                = 1'b0;
    cfg_bypass_all();
    chn_if.chn_data_in     = '0;
    chn_if.chn_alu_op      = '0;
    chn_if.chn_mul_op      = '0;
    chn_if.chn_in_pvld     = 1'b0;
    chn_if.chn_alu_op_pvld = 1'b0;
    chn_if.chn_mul_op_pvld = 1'b0;
    chn_if.chn_out_prdy    = 1'b1;
    #1;
    checkOutput("rst_out_pvld", chn_if.chn_out_pvld, 0);
    checkOutput("rst_data_out", chn_if.chn_data_out, 0);
    checkOutput("rst_sat_cnt",  sat_cnt, 0);
    checkOutput("rst_idle",     pipe_idle, 1);
    checkOutput("rst_in_prdy",  chn_if.chn_in_prdy, 1);
    @(negedge nvdla_core_clk);
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;

    $display("[TB] ALU SUM register operand");
    lat_chk = 1'b1;
    cfg_alu_bypass = 1'b0; cfg_alu_algo = 2'd2; cfg_alu_op = 16'h0010; cfg_alu_shift_value = 6'd4;
    applyStimulus({LANES{32'd100}}, '0, '0);
    drain();
    checkOutput("alu_sum_356", last_out, {LANES{32'd356}});

    $display("[TB] MUL channel operand with rounding shift");
    cfg_bypass_all();
    cfg_mul_bypass = 1'b0; cfg_mul_src = 1'b1; cfg_mul_shift_value = 6'd1;
    applyStimulus({LANES{32'd5}}, '0, {LANES{16'hFFFD}});
    drain();
    checkOutput("mul_round_m7", last_out, {LANES{32'hFFFF_FFF9}});
    cfg_relu_bypass = 1'b0;
    applyStimulus({LANES{32'd5}}, '0, {LANES{16'hFFFD}});
    drain();
    checkOutput("mul_relu_0", last_out, '0);

    $display("[TB] saturation and counter clear");
    cfg_bypass_all();
    cfg_mul_bypass = 1'b0; cfg_mul_op = 16'h7FFF;
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    applyStimulus({LANES{32'h7FFF_FFFF}}, '0, '0);
    drain();
    checkOutput("sat_data", last_out, {LANES{32'h7FFF_FFFF}});
    checkOutput("sat_cnt_4", sat_cnt, CNT_W'(LANES));
    checkOutput("sat_cnt_model", sat_cnt, CNT_W'(sat_model));
    lat_chk = 1'b0;
    chn_if.chn_out_prdy = 1'b0;
    applyStimulus({LANES{32'h7FFF_FFFF}}, '0, '0);
    budget = 0;
    while (!chn_if.chn_out_pvld && budget < 20) begin
      tick();
      budget++;
    end
    checkOutput("sat_wait_pvld", chn_if.chn_out_pvld, 1);
    sat_clr = 1'b1;
    chn_if.chn_out_prdy = 1'b1;
    tick();
    sat_clr = 1'b0;
    checkOutput("sat_clr_wins", sat_cnt, 0);
    drain();

    $display("[TB] PReLU");
    lat_chk = 1'b1;
    cfg_bypass_all();
    cfg_mul_bypass = 1'b0; cfg_mul_prelu = 1'b1; cfg_mul_op = 16'd2; cfg_mul_shift_value = 6'd1;
    applyStimulus({32'hFFFF_FFF8, 32'd8, 32'hFFFF_FFF8, 32'd8}, '0, '0);
    drain();
    checkOutput("prelu", last_out, {32'hFFFF_FFF8, 32'd8, 32'hFFFF_FFF8, 32'd8});

    $display("[TB] stream join");
    cfg_bypass_all();
    cfg_alu_bypass = 1'b0; cfg_alu_src = 1'b1; cfg_alu_algo = 2'd2;
    chn_if.chn_data_in = {LANES{32'd1000}};
    chn_if.chn_alu_op  = {LANES{16'd5}};
    chn_if.chn_in_pvld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("join_in_prdy", chn_if.chn_in_prdy, 0);
      checkOutput("join_alu_prdy", chn_if.chn_alu_op_prdy, 1);
      checkOutput("join_mul_prdy", chn_if.chn_mul_op_prdy, 0);
      checkOutput("join_idle", pipe_idle, 1);
    end
    applyStimulus({LANES{32'd1000}}, {LANES{16'd5}}, '0);
    drain();
    checkOutput("join_sum", last_out, {LANES{32'd1005}});

    $display("[TB] random traffic with backpressure");
    lat_chk = 1'b0;
    for (int seg = 0; seg < 4; seg++) begin
      cfg_alu_bypass = ($urandom_range(0, 3) == 0);
      cfg_alu_src = 1'($urandom); cfg_alu_algo = 2'($urandom);
      cfg_alu_op = 16'($urandom); cfg_alu_shift_value = 6'($urandom_range(0, 20));
      cfg_mul_bypass = ($urandom_range(0, 3) == 0);
      cfg_mul_src = 1'($urandom); cfg_mul_prelu = 1'($urandom);
      cfg_mul_op = 16'($urandom); cfg_mul_shift_value = 6'($urandom_range(0, 20));
      cfg_relu_bypass = 1'($urandom);
      sent = 0;
      budget = 0;
      while (sent < 250 && budget < 5000) begin
        for (int i = 0; i < LANES; i++) begin
          chn_if.chn_data_in[32*i +: 32] = $urandom;
          chn_if.chn_alu_op[16*i +: 16]  = 16'($urandom);
          chn_if.chn_mul_op[16*i +: 16]  = 16'($urandom);
        end
        chn_if.chn_in_pvld     = ($urandom_range(0, 3) != 0);
        chn_if.chn_alu_op_pvld = ($urandom_range(0, 3) != 0);
        chn_if.chn_mul_op_pvld = ($urandom_range(0, 3) != 0);
        chn_if.chn_out_prdy    = 1'($urandom);
        tick();
        if (last_fire) sent++;
        budget++;
      end
      if (sent < 250) checkOutput("random_budget", DW'(sent), 250);
      chn_if.chn_in_pvld     = 1'b0;
      chn_if.chn_alu_op_pvld = 1'b0;
      chn_if.chn_mul_op_pvld = 1'b0;
      drain();
      checkOutput("random_sat_cnt", sat_cnt, CNT_W'(sat_model));
    end

    $display("[TB] asynchronous reset with beats in flight");
    cfg_bypass_all();
    chn_if.chn_out_prdy = 1'b0;
    applyStimulus({LANES{32'd11}}, '0, '0);
    applyStimulus({LANES{32'd22}}, '0, '0);
    applyStimulus({LANES{32'd33}}, '0, '0);
    checkOutput("inflight_pvld", chn_if.chn_out_pvld, 1);
    checkOutput("inflight_idle", pipe_idle, 0);
    #2;
    nvdla_core_rstn = 1'b0;
    #1;
    checkOutput("arst_pvld", chn_if.chn_out_pvld, 0);
    checkOutput("arst_idle", pipe_idle, 1);
    checkOutput("arst_data", chn_if.chn_data_out, 0);
    sb.delete();
    sat_model = 0;
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1'b1;
    chn_if.chn_out_prdy = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checkOutput("post_rst_pvld", chn_if.chn_out_pvld, 0);
    lat_chk = 1'b1;
    applyStimulus({LANES{32'd44}}, '0, '0);
    drain();
    checkOutput("post_rst_beat", last_out, {LANES{32'd44}});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
